// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared opcodes and FSM state for the ID-stage branch hazard controller.
// Optional statistics counters are enabled with BRANCH_HAZ_STATS_EN.
package branch_ctrl_pkg;

   localparam logic [5:0] OP_J   = 6'd2;
   localparam logic [5:0] OP_BEQ = 6'd4;
   localparam logic [5:0] OP_BNE = 6'd5;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   function automatic logic is_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// ID-stage instruction, EX/MEM producer info and hazard-control outputs.
// takenCnt/stallCnt exist only with BRANCH_HAZ_STATS_EN defined.
interface branch_hazard_ctrl_if;
   logic [5:0] opCode;
   logic [4:0] rsID;
   logic [4:0] rtID;
   logic       compResult;
   logic       regWriteEX;
   logic       memReadEX;
   logic [4:0] writeRegEX;
   logic       regWriteMEM;
   logic       memReadMEM;
   logic [4:0] writeRegMEM;
   logic       stall;
   logic       bubble;
   logic       PCSrc;
   logic       flush;
   logic       jump;
   logic       fwdA;
   logic       fwdB;
`ifdef BRANCH_HAZ_STATS_EN
   logic [15:0] takenCnt;
   logic [15:0] stallCnt;
`endif

   modport master (
      output opCode, rsID, rtID, compResult,
      output regWriteEX, memReadEX, writeRegEX,
      output regWriteMEM, memReadMEM, writeRegMEM,
      input  stall, bubble, PCSrc, flush, jump, fwdA, fwdB
`ifdef BRANCH_HAZ_STATS_EN
      , input takenCnt, stallCnt
`endif
   );

   modport slave (
      input  opCode, rsID, rtID, compResult,
      input  regWriteEX, memReadEX, writeRegEX,
      input  regWriteMEM, memReadMEM, writeRegMEM,
      output stall, bubble, PCSrc, flush, jump, fwdA, fwdB
`ifdef BRANCH_HAZ_STATS_EN
      , output takenCnt, stallCnt
`endif
   );
endinterface

// File: rtl/branch_hazard_ctrl_detect.sv
// Combinational producer matching of EX/MEM writers against the ID sources.
// Register 0 never matches, so it can neither stall nor forward.
module branch_hazard_detect (
   input  logic [4:0] rsID,
   input  logic [4:0] rtID,
   input  logic       regWriteEX,
   input  logic       memReadEX,
   input  logic [4:0] writeRegEX,
   input  logic       regWriteMEM,
   input  logic       memReadMEM,
   input  logic [4:0] writeRegMEM,
   output logic       exHazLoad,
   output logic       exHazAlu,
   output logic       memHazLoad,
   output logic       memFwdA,
   output logic       memFwdB
);
   logic w_ex_live;
   logic w_mem_live;
   logic w_ex_match;
   logic w_mem_rs;
   logic w_mem_rt;

   assign w_ex_live  = regWriteEX  && (writeRegEX  != 5'd0);
   assign w_mem_live = regWriteMEM && (writeRegMEM != 5'd0);
   assign w_ex_match = w_ex_live && ((writeRegEX == rsID) || (writeRegEX == rtID));
   assign w_mem_rs   = w_mem_live && (writeRegMEM == rsID);
   assign w_mem_rt   = w_mem_live && (writeRegMEM == rtID);

   assign exHazLoad  = w_ex_match && memReadEX;
   assign exHazAlu   = w_ex_match && !memReadEX;
   assign memHazLoad = (w_mem_rs || w_mem_rt) && memReadMEM;
   assign memFwdA    = w_mem_rs && !memReadMEM;
   assign memFwdB    = w_mem_rt && !memReadMEM;
endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jump resolution with stall, bubble, flush and MEM->ID forwarding.
// Outputs are zero-latency; BRANCH_HAZ_STATS_EN adds saturating taken/stall counters.
module branch_hazard_ctrl
   import branch_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   branch_hazard_ctrl_if.slave  bus
);
   state_t r_state;
   state_t w_next;
   logic   w_ex_load, w_ex_alu, w_mem_load, w_fwd_a, w_fwd_b;
   logic   w_is_br, w_taken;

   branch_hazard_detect u_detect (
      .rsID        (bus.rsID),
      .rtID        (bus.rtID),
      .regWriteEX  (bus.regWriteEX),
      .memReadEX   (bus.memReadEX),
      .writeRegEX  (bus.writeRegEX),
      .regWriteMEM (bus.regWriteMEM),
      .memReadMEM  (bus.memReadMEM),
      .writeRegMEM (bus.writeRegMEM),
      .exHazLoad   (w_ex_load),
      .exHazAlu    (w_ex_alu),
      .memHazLoad  (w_mem_load),
      .memFwdA     (w_fwd_a),
      .memFwdB     (w_fwd_b)
   );

   assign w_is_br = is_branch(bus.opCode);
   assign w_taken = (bus.opCode == OP_BEQ) ? bus.compResult : !bus.compResult;

   always_comb begin
      w_next     = IDLE;
      bus.stall  = 1'b0;
      bus.bubble = 1'b0;
      bus.PCSrc  = 1'b0;
      bus.flush  = 1'b0;
      bus.jump   = 1'b0;
      bus.fwdA   = 1'b0;
      bus.fwdB   = 1'b0;
      if (r_state == HOLD) begin
         bus.stall  = 1'b1;
         bus.bubble = 1'b1;
      end else if (w_is_br && (w_ex_load || w_ex_alu || w_mem_load)) begin
         // Only an EX load needs the extra cycle; the others resolve on re-evaluation.
         bus.stall  = 1'b1;
         bus.bubble = 1'b1;
         w_next     = w_ex_load ? HOLD : IDLE;
      end else if (w_is_br) begin
         bus.fwdA  = w_fwd_a;
         bus.fwdB  = w_fwd_b;
         bus.PCSrc = w_taken;
         bus.flush = w_taken;
      end else if (bus.opCode == OP_J) begin
         bus.jump  = 1'b1;
         bus.flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

`ifdef BRANCH_HAZ_STATS_EN
   logic [15:0] r_taken_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_taken_cnt <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         if (bus.PCSrc && (r_taken_cnt != 16'hFFFF)) r_taken_cnt <= r_taken_cnt + 16'd1;
         if (bus.stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign bus.takenCnt = r_taken_cnt;
   assign bus.stallCnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Randomized + directed scoreboard bench for branch_hazard_ctrl.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_branch_hazard_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_hazard_ctrl_if bus ();
   branch_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      bit          chk;
      logic [6:0]  outs;
      logic [15:0] tc;
      logic [15:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state: extra stall cycles owed by an earlier EX load.
   int   m_owed = 0;
   int   m_taken = 0;
   int   m_stalls = 0;
   bit   m_last_stall = 0;

   function automatic bit produces(input bit we, input int wr, input int rs, input int rt);
      return we && wr != 0 && (wr == rs || wr == rt);
   endfunction

   task automatic drive(input int op, input int rs, input int rt, input bit cmp,
                        input bit rwe, input bit mre, input int wre,
                        input bit rwm, input bit mrm, input int wrm, input bit r);
      exp_t e;
      bit st, pc, fl, jp, fa, fb;
      bit br;
      int owed_next;
      @(posedge clk);
      #1;
      rst = r;
      bus.opCode = 6'(op); bus.rsID = 5'(rs); bus.rtID = 5'(rt); bus.compResult = cmp;
      bus.regWriteEX = rwe; bus.memReadEX = mre; bus.writeRegEX = 5'(wre);
      bus.regWriteMEM = rwm; bus.memReadMEM = mrm; bus.writeRegMEM = 5'(wrm);
      st = 0; pc = 0; fl = 0; jp = 0; fa = 0; fb = 0;
      br = (op == 4 || op == 5);
      owed_next = 0;
      if (m_owed > 0) begin
         st = 1;
         owed_next = m_owed - 1;
      end else if (br && (produces(rwe, wre, rs, rt) || (mrm && produces(rwm, wrm, rs, rt)))) begin
         st = 1;
         owed_next = (produces(rwe, wre, rs, rt) && mre) ? 1 : 0;
      end else if (br) begin
         fa = rwm && !mrm && wrm != 0 && wrm == rs;
         fb = rwm && !mrm && wrm != 0 && wrm == rt;
         pc = (op == 4) ? cmp : !cmp;
         fl = pc;
      end else if (op == 2) begin
         jp = 1; fl = 1;
      end
      e.chk  = !r;
      e.outs = {st, st, pc, fl, jp, fa, fb};
      e.tc   = 16'(m_taken);
      e.sc   = 16'(m_stalls);
      exp_q.push_back(e);
      if (r) begin
         m_owed = 0; m_taken = 0; m_stalls = 0;
      end else begin
         m_owed = owed_next;
         if (pc && m_taken < 65535) m_taken++;
         if (st && m_stalls < 65535) m_stalls++;
      end
      m_last_stall = st && !r;
   endtask

   task automatic idle(input bit r);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r);
   endtask

   initial begin : monitor
      exp_t e;
      logic [6:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               got = {bus.stall, bus.bubble, bus.PCSrc, bus.flush, bus.jump, bus.fwdA, bus.fwdB};
               checks++;
               if (got !== e.outs) begin
                  failures++;
                  $display("FAIL outs {stall,bubble,PCSrc,flush,jump,fwdA,fwdB} got=%b want=%b t=%0t",
                           got, e.outs, $time);
               end
`ifdef BRANCH_HAZ_STATS_EN
               checks++;
               if (bus.takenCnt !== e.tc || bus.stallCnt !== e.sc) begin
                  failures++;
                  $display("FAIL counters taken got=%h want=%h stall got=%h want=%h t=%0t",
                           bus.takenCnt, e.tc, bus.stallCnt, e.sc, $time);
               end
`endif
            end
         end
      end
   end

   initial begin : stim
      int op, rs, rt;
      int ops[5];
      int wait_cyc;
      ops = '{0, 2, 4, 5, 7};
      rst = 1'b1;
      idle(1); idle(1);
      idle(0);
      // beq r1,r2 behind an EX lw of r1: two stall cycles then taken
      drive(4, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0);
      drive(4, 1, 2, 1, 0, 0, 0, 1, 1, 1, 0);
      drive(4, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
      // bne r3,r4 behind an EX add of r4: one stall then forward rt
      drive(5, 3, 4, 0, 1, 0, 4, 0, 0, 0, 0);
      drive(5, 3, 4, 0, 0, 0, 0, 1, 0, 4, 0);
      // MEM add writing r0 never forwards
      drive(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
      drive(4, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      // jump ignores hazards
      drive(2, 6, 7, 0, 1, 1, 6, 0, 0, 0, 0);
      // reset taken in HOLD
      drive(4, 1, 2, 0, 1, 1, 2, 0, 0, 0, 0);
      idle(1);
      idle(0);
      drive(5, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
      // randomized traffic; a stalled ID instruction stays frozen
      op = 4; rs = 1; rt = 2;
      for (int i = 0; i < 3000; i++) begin
         if (!m_last_stall) begin
            op = ops[$urandom_range(0, 4)];
            rs = $urandom_range(0, 3);
            rt = $urandom_range(0, 3);
         end
         drive(op, rs, rt, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 99) == 0);
      end
`ifdef BRANCH_HAZ_STATS_EN
      idle(1);
      while (m_stalls < 16'hFFFE) drive(5, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(5, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
      idle(0);
      @(negedge clk);
      checks++;
      if (bus.stallCnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL stall_sat got=%h want=ffff", bus.stallCnt);
      end
`endif
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 opCode  in  6  opcode of the instruction in ID.
REQ-005 rsID, rtID  in  5 each  source registers of the ID instruction.
REQ-006 compResult  in  1  ID-stage equality result, computed with the fwdA/fwdB selects below.
REQ-007 regWriteEX, memReadEX  in  1 each; writeRegEX  in  5  EX-stage producer.
REQ-008 regWriteMEM, memReadMEM  in  1 each; writeRegMEM  in  5  MEM-stage producer.
REQ-009 stall  out  1  freeze PC and IF/ID.
REQ-010 bubble  out  1  zero ID/EX control signals.
REQ-011 PCSrc  out  1  select branch target.
REQ-012 flush  out  1  clear IF/ID.
REQ-013 jump  out  1  select jump target.
REQ-014 fwdA, fwdB  out  1 each  route the MEM-stage ALU result to comparator operand rs/rt.

Function
REQ-015 A branch is opCode 4 (beq) or 5 (bne); a jump is opCode 2; any other opcode SHALL produce all outputs 0.
REQ-016 A producer matches when it has regWrite=1, writeReg!=0, and writeReg equal to rsID or rtID.
REQ-017 The FSM SHALL have two states: IDLE and HOLD.
REQ-018 In IDLE, a branch with a matching EX load SHALL assert stall=bubble=1 and go to HOLD.
REQ-019 In IDLE, a branch with a matching EX non-load or a matching MEM load SHALL assert stall=bubble=1 and stay in IDLE, re-evaluating next cycle.
REQ-020 In HOLD, stall=bubble=1 unconditionally, hazard inputs are ignored, and the next state is IDLE.
REQ-021 In IDLE with no stall, fwdA (fwdB) SHALL be 1 iff the MEM producer is a non-load that matches rsID (rtID).
REQ-022 In IDLE with no stall, PCSrc=flush=1 for beq with compResult=1 or bne with compResult=0, in the same cycle (zero latency).
REQ-023 In IDLE, a jump SHALL give jump=flush=1 with no stall, regardless of the hazard inputs.
REQ-024 While stall=1, PCSrc, flush, jump, fwdA and fwdB SHALL all be 0.
REQ-025 When both the EX and MEM producers match, the EX condition (REQ-018/019) SHALL take precedence.
REQ-026 Register 0 SHALL never cause a hazard or a forward.

Reset
REQ-027 On clk with rst=1, the state SHALL become IDLE, including when reset occurs mid-HOLD.
REQ-028 While the state is IDLE after reset, outputs follow REQ-018..026; after a reset taken in HOLD, stall SHALL be 0 in the next cycle unless a new hazard is present.

Configuration
REQ-029 With BRANCH_HAZ_STATS_EN defined, the block SHALL add outputs takenCnt[15:0] (+1 per PCSrc cycle) and stallCnt[15:0] (+1 per stall cycle).
REQ-030 Both counters SHALL saturate at 16'hFFFF and clear to 0 on rst.
REQ-031 Without BRANCH_HAZ_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package branch_ctrl_pkg SHALL hold OP_BEQ=6'd4, OP_BNE=6'd5, OP_J=6'd2 and the state enum {IDLE, HOLD}.
REQ-033 Producer matching SHALL be a combinational sub-module branch_hazard_detect with outputs exHazLoad, exHazAlu, memHazLoad, memFwdA, memFwdB.

Verification
REQ-034 beq r1,r2 with EX lw writing r1 -> stall=1 for 2 cycles (IDLE, HOLD), then fwd=0; compResult=1 gives PCSrc=flush=1 on cycle 3.
REQ-035 bne r3,r4 with EX add writing r4 -> stall for 1 cycle; next cycle fwdB=1, fwdA=0; compResult=0 gives PCSrc=flush=1.
REQ-036 beq with a MEM producer add writing r0 -> no stall, fwdA=fwdB=0.
REQ-037 opCode=2 with EX lw writing rsID -> jump=flush=1, stall=0 in the same cycle.
REQ-038 rst=1 asserted during HOLD -> state is IDLE next cycle, stall=0 with hazard inputs cleared; with STATS_EN, both counters read 0.
REQ-039 With STATS_EN, preload stallCnt to 16'hFFFE and apply 3 stall cycles -> reads 16'hFFFF.
